position_overlay: RTL
=====================

// Module: position_overlay
// PURPOSE
//  Downstream consumer of the position solver. Takes each solved image coordinate (x_2d, y_2d, done
//  pulse) and runs a 2^AVG_LOG2-deep moving average with clamping. It latches the smoothed point at
//  frame boundaries so the marker never tears, and draws a crosshair onto the camera pixel stream.
//  It hides the marker when no fresh solution arrives within TIMEOUT_FRAMES frames.
// PARAMETERS
//  H_ACTIVE        640      active pixels per line; x clamp limit
//  V_ACTIVE        480      active lines per frame; y clamp limit
//  AVG_LOG2        2        log2 of averaging depth (DEPTH = 4)
//  ARM_LEN         8        crosshair half-length, pixels
//  TIMEOUT_FRAMES  3        frames without a sample before the marker is hidden
//  MARK_COLOR      16'hF800 RGB565 crosshair colour
// PORTS
//  clk          in   1   system/pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  pos_valid    in   1   one-cycle pulse: x_2d/y_2d are valid (solver done)
//  x_2d         in   32  solved column, signed two's complement
//  y_2d         in   32  solved row, signed two's complement
//  frame_start  in   1   one-cycle pulse before the first active pixel of a frame
//  de_in        in   1   pixel data enable
//  pix_x        in   12  current pixel column
//  pix_y        in   12  current pixel row
//  pixel_in     in   16  RGB565 camera pixel
//  de_out       out  1   de_in delayed 1 cycle
//  pixel_out    out  16  overlaid pixel, 1-cycle latency
//  mark_x       out  12  displayed marker column
//  mark_y       out  12  displayed marker row
//  mark_valid   out  1   marker drawn this frame
//  busy         out  1   smoothing FSM not in IDLE
//  drop_cnt     out  8   saturating count of pos_valid pulses ignored while busy
// BEHAVIOUR
//  Reset: every output is 0. All buffer entries, sums, pend_*, live, and the frame counter are also 0.
//  Smoothing FSM states: IDLE, CLAMP, PRELOAD, ACCUM, OUT.
//  - IDLE: on pos_valid, capture x_2d/y_2d and go to CLAMP. A pos_valid in any other state is dropped
//    and increments drop_cnt, which saturates at 255.
//  - CLAMP (1 cycle): values < 0 become 0. x >= H_ACTIVE becomes H_ACTIVE-1. y >= V_ACTIVE becomes
//    V_ACTIVE-1. Truncate to 12 bits. Go to PRELOAD if live==0, otherwise go to ACCUM.
//  - PRELOAD (DEPTH cycles): write the sample into entries 0..DEPTH-1, one per cycle.
//    Set sum = sample<<AVG_LOG2 and wr_ptr = 0. Go to OUT.
//  - ACCUM (1 cycle): sum <= sum - buf[wr_ptr] + sample; buf[wr_ptr] <= sample;
//    wr_ptr wraps modulo DEPTH. Go to OUT.
//  - OUT (1 cycle): pend_x/pend_y <= sum>>AVG_LOG2; live <= 1; frame counter <= 0. Go to IDLE.
//  - Latency from pos_valid to pend update: 3 cycles (live path) or DEPTH+2 cycles (preload path).
//  - Sum width is 12+AVG_LOG2 bits and cannot overflow.
//  Frame latch: on frame_start, mark_x/mark_y <= pend_x/pend_y and mark_valid <= live.
//    The frame counter increments, saturating at TIMEOUT_FRAMES. When it reaches TIMEOUT_FRAMES,
//    live <= 0 and mark_valid <= 0 on that same frame_start.
//  Simultaneous frame_start and OUT: OUT takes priority for live/counter. The latch uses the old pend.
//  Overlay (registered, 1 cycle): hit = mark_valid && ((pix_y==mark_y && |pix_x-mark_x|<=ARM_LEN) ||
//    (pix_x==mark_x && |pix_y-mark_y|<=ARM_LEN)). Use 13-bit signed differences; no wrap at edges.
//    pixel_out = !de_in ? 0 : hit ? MARK_COLOR : pixel_in.
//  Reset mid-operation: the FSM returns to IDLE, the buffer clears, and the next sample preloads.
// STRUCTURE
//  Shared package: FSM state encoding, RGB565 type, and clamp/coordinate width constant (12).
//  One sub-module, pos_avg_channel: clamp + buffer + running sum for one axis, instantiated for x and y
//  under the shared FSM. Overlay compare and frame latch stay in the top.
// TESTING (H_ACTIVE=640, V_ACTIVE=480, AVG_LOG2=2, ARM_LEN=8, TIMEOUT_FRAMES=3)
//  1 Reset asserted mid-PRELOAD -> all outputs 0; after release, a sample (10,10) preloads afresh.
//  2 First sample (100,50) -> busy for 6 cycles, pend=(100,50); next frame_start gives mark=(100,50) valid.
//  3 Samples x=100 then x=200 -> sum 400-100+200=500 -> pend_x=125.
//  4 x_2d=-5, y_2d=1000 -> clamped to (0,479); x=700 -> 639.
//  5 mark=(100,50), de_in=1: pix (108,50) -> MARK_COLOR; (109,50) -> pixel_in; (100,42) -> MARK_COLOR;
//    de_in=0 -> 0.
//  6 No samples for 3 frame_starts -> mark_valid 0 on the third. Next sample 300 -> pend_x=300, no blend.
//    A pos_valid while busy -> drop_cnt increments by 1.

Source files
------------

// File: rtl/position_overlay_pkg.sv
// Shared types and constants for the position overlay: smoothing FSM states,
// pixel type, coordinate width and the coordinate clamp helper.
package position_overlay_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAMP,
        ST_PRELOAD,
        ST_ACCUM,
        ST_OUT
    } avg_state_t;

    typedef logic [15:0] rgb565_t;

    // Negative coordinates pin to 0 and large ones pin to limit-1, so the
    // sample always lands inside the active area.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [31:0] v,
                                                       input int limit);
        logic [COORD_W-1:0] r;
        if (v < 0)
            r = '0;
        else if (v >= limit)
            r = COORD_W'(limit - 1);
        else
            r = v[COORD_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/pos_avg_channel.sv
// One axis of the moving average: raw capture, clamp, sample history and
// running sum. Sequencing comes from the shared FSM in the top.
module pos_avg_channel
    import position_overlay_pkg::*;
#(
    parameter int LIMIT    = 640,
    parameter int AVG_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cap_en,
    input  logic                      clamp_en,
    input  logic                      pre_en,
    input  logic                      acc_en,
    input  logic [AVG_LOG2-1:0]       pre_idx,
    input  logic [AVG_LOG2-1:0]       wr_ptr,
    input  logic signed [31:0]        raw_in,
    output logic [COORD_W-1:0]        avg
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = COORD_W + AVG_LOG2;

    logic signed [31:0]   raw_reg;
    logic [COORD_W-1:0]   sample_reg;
    logic [COORD_W-1:0]   buf_mem [DEPTH];
    logic [SUM_W-1:0]     sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_reg    <= '0;
            sample_reg <= '0;
            sum_reg    <= '0;
            for (int i = 0; i < DEPTH; i++)
                buf_mem[i] <= '0;
        end else begin
            if (cap_en)
                raw_reg <= raw_in;
            if (clamp_en)
                sample_reg <= clamp_coord(raw_reg, LIMIT);
            // Preload fills the whole history with one sample, so the sum is
            // simply that sample times the depth.
            if (pre_en) begin
                buf_mem[pre_idx] <= sample_reg;
                sum_reg          <= SUM_W'(sample_reg) << AVG_LOG2;
            end
            if (acc_en) begin
                buf_mem[wr_ptr] <= sample_reg;
                sum_reg         <= sum_reg - SUM_W'(buf_mem[wr_ptr]) + SUM_W'(sample_reg);
            end
        end
    end

    assign avg = COORD_W'(sum_reg >> AVG_LOG2);

endmodule

// File: rtl/position_overlay.sv
// Smooths solver coordinates, latches them at frame boundaries and draws a
// crosshair onto the pixel stream; the marker hides after a sample timeout.
module position_overlay
    import position_overlay_pkg::*;
#(
    parameter int      H_ACTIVE       = 640,
    parameter int      V_ACTIVE       = 480,
    parameter int      AVG_LOG2       = 2,
    parameter int      ARM_LEN        = 8,
    parameter int      TIMEOUT_FRAMES = 3,
    parameter rgb565_t MARK_COLOR     = 16'hF800
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pos_valid,
    input  logic signed [31:0]  x_2d,
    input  logic signed [31:0]  y_2d,
    input  logic                frame_start,
    input  logic                de_in,
    input  logic [COORD_W-1:0]  pix_x,
    input  logic [COORD_W-1:0]  pix_y,
    input  logic [15:0]         pixel_in,
    output logic                de_out,
    output logic [15:0]         pixel_out,
    output logic [COORD_W-1:0]  mark_x,
    output logic [COORD_W-1:0]  mark_y,
    output logic                mark_valid,
    output logic                busy,
    output logic [7:0]          drop_cnt
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

    avg_state_t           state_reg, state_next;
    logic [AVG_LOG2-1:0]  pre_cnt_reg;
    logic [AVG_LOG2-1:0]  wr_ptr_reg;
    logic                 live_reg;
    logic [CNT_W-1:0]     frame_cnt_reg;
    logic [COORD_W-1:0]   pend_x_reg, pend_y_reg;
    logic [COORD_W-1:0]   mark_x_reg, mark_y_reg;
    logic                 mark_valid_reg;
    logic [7:0]           drop_cnt_reg;
    logic                 de_out_reg;
    rgb565_t              pixel_out_reg;

    logic                 cap_en, clamp_en, pre_en, acc_en;
    logic signed [31:0]   raw_in [2];
    logic [COORD_W-1:0]   avg [2];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (pos_valid) state_next = ST_CLAMP;
            ST_CLAMP:   state_next = live_reg ? ST_ACCUM : ST_PRELOAD;
            ST_PRELOAD: if (pre_cnt_reg == AVG_LOG2'(DEPTH - 1)) state_next = ST_OUT;
            ST_ACCUM:   state_next = ST_OUT;
            ST_OUT:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign cap_en   = (state_reg == ST_IDLE) && pos_valid;
    assign clamp_en = (state_reg == ST_CLAMP);
    assign pre_en   = (state_reg == ST_PRELOAD);
    assign acc_en   = (state_reg == ST_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pre_cnt_reg  <= '0;
            wr_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pre_cnt_reg <= pre_en ? pre_cnt_reg + 1'b1 : '0;
            if (pre_en)
                wr_ptr_reg <= '0;
            else if (acc_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pos_valid && state_reg != ST_IDLE && drop_cnt_reg != 8'hFF)
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign raw_in[0] = x_2d;
    assign raw_in[1] = y_2d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            pos_avg_channel #(
                .LIMIT    ((gi == 0) ? H_ACTIVE : V_ACTIVE),
                .AVG_LOG2 (AVG_LOG2)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .cap_en   (cap_en),
                .clamp_en (clamp_en),
                .pre_en   (pre_en),
                .acc_en   (acc_en),
                .pre_idx  (pre_cnt_reg),
                .wr_ptr   (wr_ptr_reg),
                .raw_in   (raw_in[gi]),
                .avg      (avg[gi])
            );
        end
    endgenerate

    // A fresh result in OUT wins over a coincident frame_start for live and
    // the counter; the latch itself always takes the previous pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x_reg     <= '0;
            pend_y_reg     <= '0;
            live_reg       <= 1'b0;
            frame_cnt_reg  <= '0;
            mark_x_reg     <= '0;
            mark_y_reg     <= '0;
            mark_valid_reg <= 1'b0;
        end else begin
            if (state_reg == ST_OUT) begin
                pend_x_reg    <= avg[0];
                pend_y_reg    <= avg[1];
                live_reg      <= 1'b1;
                frame_cnt_reg <= '0;
            end
            if (frame_start) begin
                mark_x_reg <= pend_x_reg;
                mark_y_reg <= pend_y_reg;
                if (state_reg == ST_OUT) begin
                    mark_valid_reg <= live_reg;
                end else begin
                    if (int'(frame_cnt_reg) < TIMEOUT_FRAMES)
                        frame_cnt_reg <= frame_cnt_reg + 1'b1;
                    if (int'(frame_cnt_reg) >= TIMEOUT_FRAMES - 1) begin
                        live_reg       <= 1'b0;
                        mark_valid_reg <= 1'b0;
                    end else begin
                        mark_valid_reg <= live_reg;
                    end
                end
            end
        end
    end

    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0]        adx, ady;
    logic                    hit;

    always_comb begin
        dx  = $signed({1'b0, pix_x}) - $signed({1'b0, mark_x_reg});
        dy  = $signed({1'b0, pix_y}) - $signed({1'b0, mark_y_reg});
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        hit = mark_valid_reg &&
              (((pix_y == mark_y_reg) && (adx <= (COORD_W+1)'(ARM_LEN))) ||
               ((pix_x == mark_x_reg) && (ady <= (COORD_W+1)'(ARM_LEN))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out_reg    <= 1'b0;
            pixel_out_reg <= '0;
        end else begin
            de_out_reg    <= de_in;
            pixel_out_reg <= !de_in ? rgb565_t'(0) : (hit ? MARK_COLOR : pixel_in);
        end
    end

    assign de_out     = de_out_reg;
    assign pixel_out  = pixel_out_reg;
    assign mark_x     = mark_x_reg;
    assign mark_y     = mark_y_reg;
    assign mark_valid = mark_valid_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign drop_cnt   = drop_cnt_reg;

endmodule
